// File: rtl/data_mem_if.sv
`default_nettype none
// ---------------------------------------------------------------
// data_mem_if : load/store request and response bus for data_mem
// rev 1.0
// ---------------------------------------------------------------
interface data_mem_if #(
  parameter int ADDR_W = 10
) ();
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sext;
  logic [ADDR_W+1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rvalid;
  logic              ready;
  logic              align_err;

  modport master (
    output req, we, size, sext, addr, wdata,
    input  rdata, rvalid, ready, align_err
  );

  modport slave (
    input  req, we, size, sext, addr, wdata,
    output rdata, rvalid, ready, align_err
  );
endinterface
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ---------------------------------------------------------------
// data_mem : byte-addressable 32-bit data memory with clear sweep
// rev 1.0
// ---------------------------------------------------------------
module data_mem #(
  parameter int ADDR_W         = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_if.slave         bus,
  input  logic              clear_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [31:0]       disp_data
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] word_addr;
  logic [1:0]        off;
  logic              misaligned, accept, store_en, load_en;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;

  logic [31:0]       ram_q;
  logic              ld_pend;
  logic [1:0]        ld_off, ld_size;
  logic              ld_sext;
  logic [31:0]       ld_fmt;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign word_addr = bus.addr[ADDR_W+1:2];
  assign off       = bus.addr[1:0];
  assign bus.ready = (state_q == ST_RUN);

  // A clear request wins over a same-cycle access, which is dropped.
  assign misaligned = (bus.size == 2'b11) ||
                      (bus.size == 2'b01 && off[0]) ||
                      (bus.size == 2'b10 && off != 2'b00);
  assign accept     = bus.req && bus.ready && !clear_req;
  assign store_en   = accept && bus.we && !misaligned;
  assign load_en    = accept && !bus.we && !misaligned;

  always_comb begin
    st_be   = 4'b1111;
    st_data = bus.wdata;
    case (bus.size)
      2'b00: begin
        st_be   = 4'b0001 << off;
        st_data = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        st_be   = off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{bus.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = word_addr;
    wr_be   = st_be;
    wr_data = st_data;
    case (state_q)
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_be   = 4'b1111;
        wr_data = 32'h0;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}})
          state_d = ST_RUN;
      end
      ST_RUN: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (store_en) begin
          wr_en = 1'b1;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // Array and raw read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i])
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    ram_q <= mem[word_addr];
  end

  always_comb begin
    ld_byte = ram_q[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? ram_q[31:16] : ram_q[15:0];
    case (ld_size)
      2'b00:   ld_fmt = {{24{ld_sext & ld_byte[7]}}, ld_byte};
      2'b01:   ld_fmt = {{16{ld_sext & ld_half[15]}}, ld_half};
      default: ld_fmt = ram_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RESET_STATE;
      cnt_q         <= '0;
      ld_pend       <= 1'b0;
      ld_off        <= 2'b00;
      ld_size       <= 2'b00;
      ld_sext       <= 1'b0;
      bus.rdata     <= 32'h0;
      bus.rvalid    <= 1'b0;
      bus.align_err <= 1'b0;
      disp_data     <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ld_pend       <= load_en;
      if (load_en) begin
        ld_off  <= off;
        ld_size <= bus.size;
        ld_sext <= bus.sext;
      end
      bus.rvalid    <= ld_pend;
      if (ld_pend)
        bus.rdata <= ld_fmt;
      bus.align_err <= accept && misaligned;
      disp_data     <= mem[disp_addr];
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_data_mem.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_data_mem : directed self-checking bench for data_mem (ADDR_W=4)
// rev 1.0
// ---------------------------------------------------------------
module tb_data_mem;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [31:0]   disp_data;
  int            checks = 0;
  int            errors = 0;
  int            n;

  data_mem_if #(.ADDR_W(AW)) bus ();

  data_mem #(.ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clear_req (clear_req),
    .disp_addr (disp_addr),
    .disp_data (disp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic sext,
                       input logic [AW+1:0] addr, input logic [31:0] wdata);
    bus.req   = 1'b1;
    bus.we    = we;
    bus.size  = size;
    bus.sext  = sext;
    bus.addr  = addr;
    bus.wdata = wdata;
  endtask

  task automatic idle();
    bus.req = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic store(input logic [1:0] size, input logic [AW+1:0] addr, input logic [31:0] wdata);
    drive(1'b1, size, 1'b0, addr, wdata);
    tick();
    idle();
  endtask

  task automatic load(input string tag, input logic [1:0] size, input logic sext,
                      input logic [AW+1:0] addr, input logic [31:0] exp);
    drive(1'b0, size, sext, addr, 32'h0);
    tick();
    idle();
    check({tag, "_early"}, {31'h0, bus.rvalid}, 32'h0);
    tick();
    check({tag, "_rvalid"}, {31'h0, bus.rvalid}, 32'h1);
    check(tag, bus.rdata, exp);
  endtask

  task automatic bad(input string tag, input logic we, input logic [1:0] size,
                     input logic [AW+1:0] addr, input logic [31:0] prev);
    drive(we, size, 1'b0, addr, 32'hDEAD_BEEF);
    tick();
    idle();
    check({tag, "_err"}, {31'h0, bus.align_err}, 32'h1);
    check({tag, "_rv0"}, {31'h0, bus.rvalid}, 32'h0);
    tick();
    check({tag, "_err_end"}, {31'h0, bus.align_err}, 32'h0);
    check({tag, "_rv1"}, {31'h0, bus.rvalid}, 32'h0);
    check({tag, "_rdata"}, bus.rdata, prev);
  endtask

  task automatic wait_ready(input string tag, input int start, input int exp_cycles);
    n = start;
    while (!bus.ready && n < 64) begin
      tick();
      n++;
    end
    check(tag, n, exp_cycles);
  endtask

  task automatic all_zero(input string tag);
    for (int i = 0; i < (1 << AW); i++) begin
      disp_addr = AW'(i);
      tick();
      check(tag, disp_data, 32'h0);
    end
  endtask

  initial begin
    idle();
    bus.size  = 2'b10;
    bus.sext  = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;

    // Reset values
    #2 rst = 1'b0;
    #1;
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_rvalid", {31'h0, bus.rvalid}, 32'h0);
    check("rst_align", {31'h0, bus.align_err}, 32'h0);
    check("rst_disp", disp_data, 32'h0);
    check("rst_ready", {31'h0, bus.ready}, 32'h0);

    @(negedge clk) rst = 1'b1;
    wait_ready("sweep_len", 0, 16);
    all_zero("init_zero");

    // Load formatting
    store(2'b10, 6'h08, 32'h8081_F2F3);
    load("lb_sext", 2'b00, 1'b1, 6'h09, 32'hFFFF_FFF2);
    load("lh_zext", 2'b01, 1'b0, 6'h0A, 32'h0000_8081);
    load("lh_sext", 2'b01, 1'b1, 6'h0A, 32'hFFFF_8081);
    load("lb_zext", 2'b00, 1'b0, 6'h0B, 32'h0000_0080);
    load("lw", 2'b10, 1'b1, 6'h08, 32'h8081_F2F3);

    // Byte/half lane stores and read-after-write
    store(2'b10, 6'h0C, 32'h1122_3344);
    store(2'b00, 6'h0D, 32'h0000_00AA);
    load("raw_byte", 2'b10, 1'b0, 6'h0C, 32'h1122_AA44);
    store(2'b01, 6'h0E, 32'hFFFF_BEEF);
    load("raw_half", 2'b10, 1'b0, 6'h0C, 32'hBEEF_AA44);

    // Misaligned and reserved accesses
    bad("mis_sw", 1'b1, 2'b10, 6'h06, 32'hBEEF_AA44);
    bad("mis_lh", 1'b0, 2'b01, 6'h03, 32'hBEEF_AA44);
    bad("rsv", 1'b0, 2'b11, 6'h00, 32'hBEEF_AA44);
    disp_addr = 4'd1;
    tick();
    check("mis_nowrite", disp_data, 32'h0);
    load("mis_nowrite2", 2'b10, 1'b0, 6'h00, 32'h0);

    // Clear request colliding with a load; accesses during the sweep
    drive(1'b0, 2'b10, 1'b0, 6'h08, 32'h0);
    clear_req = 1'b1;
    tick();
    idle();
    clear_req = 1'b0;
    check("clr_ready", {31'h0, bus.ready}, 32'h0);
    check("clr_rv0", {31'h0, bus.rvalid}, 32'h0);
    tick();
    check("clr_drop", {31'h0, bus.rvalid}, 32'h0);
    drive(1'b1, 2'b10, 1'b0, 6'h00, 32'hFFFF_FFFF);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    drive(1'b0, 2'b10, 1'b0, 6'h00, 32'h0);
    tick();
    idle();
    tick();
    check("sweep_rv", {31'h0, bus.rvalid}, 32'h0);
    check("sweep_err", {31'h0, bus.align_err}, 32'h0);
    wait_ready("clr_len", 4, 16);
    all_zero("clr_zero");

    // Reset in the middle of a sweep
    store(2'b10, 6'h04, 32'hCAFE_F00D);
    store(2'b10, 6'h30, 32'h55AA_55AA);
    load("pre_rst", 2'b10, 1'b0, 6'h04, 32'hCAFE_F00D);
    disp_addr = 4'd12;
    tick();
    check("disp_word", disp_data, 32'h55AA_55AA);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (7) tick();
    check("disp_partial", disp_data, 32'h55AA_55AA);
    #2 rst = 1'b0;
    #1;
    check("mid_rdata", bus.rdata, 32'h0);
    check("mid_rvalid", {31'h0, bus.rvalid}, 32'h0);
    check("mid_align", {31'h0, bus.align_err}, 32'h0);
    check("mid_disp", disp_data, 32'h0);
    check("mid_ready", {31'h0, bus.ready}, 32'h0);
    @(negedge clk) rst = 1'b1;
    wait_ready("restart_len", 0, 16);
    all_zero("restart_zero");
    load("post_rst", 2'b10, 1'b0, 6'h04, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter ADDR_W, default 10: word-address width; depth = 2^ADDR_W words of 32 bits.
REQ-002 Parameter CLEAR_ON_RESET, default 1: 1 = hardware clear sweep after reset; 0 = go directly to RUN.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  access request, sampled while ready=1.
REQ-006 we  input  1  1 = store, 0 = load.
REQ-007 size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 sext  input  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-009 addr  input  ADDR_W+2  byte address; addr[ADDR_W+1:2] = word, addr[1:0] = byte offset.
REQ-010 wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 clear_req  input  1  single-cycle request to start a clear sweep.
REQ-012 disp_addr  input  ADDR_W  debug/display word address.
REQ-013 rdata  output  32  load result, registered.
REQ-014 rvalid  output  1  one-cycle pulse marking a new rdata.
REQ-015 ready  output  1  1 = accepting requests (RUN state).
REQ-016 align_err  output  1  one-cycle pulse: rejected misaligned or reserved access.
REQ-017 disp_data  output  32  registered word at disp_addr.

Function
REQ-018 The FSM SHALL have two states: CLEAR (ready=0) and RUN (ready=1).
REQ-019 In CLEAR, one word SHALL be zeroed per cycle at counter 0, 1, ... 2^ADDR_W-1; the cycle after the last address is written, the state SHALL be RUN.
REQ-020 A clear sweep SHALL take exactly 2^ADDR_W cycles.
REQ-021 In RUN, clear_req=1 SHALL enter CLEAR with the counter at 0; a req in the same cycle SHALL be dropped (no write, no rvalid, no align_err).
REQ-022 clear_req during CLEAR SHALL be ignored; the sweep is not restarted.
REQ-023 req while ready=0 SHALL be ignored, with no side effects.
REQ-024 Store lanes:
  - byte: wdata[7:0] to lane addr[1:0].
  - half: wdata[15:0] to lanes {addr[1],1}:{addr[1],0}.
  - word: all four lanes.
  - Unselected lanes SHALL be unchanged.
REQ-025 Misalignment: half with addr[0]=1, word with addr[1:0]!=0, or size=11 SHALL:
  - not write memory;
  - not pulse rvalid;
  - leave rdata unchanged;
  - pulse align_err on the following cycle.
REQ-026 Load latency SHALL be 1 cycle: accepted at edge N, then rdata and rvalid=1 valid after edge N+1; rvalid SHALL be 0 otherwise.
REQ-027 Load data: selected byte/half SHALL be shifted to bit 0 and extended to 32 bits per sext; word loads SHALL ignore sext.
REQ-028 rdata SHALL hold its value until the next accepted load.
REQ-029 Read-after-write SHALL return data written on any earlier edge; a load in the cycle after a store to the same word SHALL see the new data.
REQ-030 disp_data SHALL be updated every cycle from disp_addr, independent of state, and SHALL return current array contents (including partially cleared words).
REQ-031 The memory array SHALL be single-write-port and SHALL be inferable as block RAM plus a registered read port.

Reset
REQ-032 On rst=0, without waiting for clk, outputs SHALL be:
  - rdata=0, rvalid=0, align_err=0, disp_data=0;
  - counter=0;
  - state=CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-033 Reset SHALL NOT directly modify the array; array contents are cleared only by the sweep.
REQ-034 Reset asserted mid-sweep SHALL restart the sweep from address 0 after release.

Verification
REQ-035 Reset release, CLEAR_ON_RESET=1, ADDR_W=4 -> ready=0 for exactly 16 cycles, then ready=1; every word reads 0.
REQ-036 Store word 0x8081_F2F3 at byte address 0x08:
  - byte load, sext=1, addr 0x09 -> rdata=0xFFFF_FFF2 with rvalid one cycle after accept;
  - half load, sext=0, addr 0x0A -> rdata=0x0000_8081.
REQ-037 Store byte 0xAA at addr 0x0D over word 0x1122_3344 -> word load returns 0x1122_AA44 on the cycle immediately following the store.
REQ-038 Word store to addr 0x06, and half load at addr 0x03 -> align_err pulses once each; memory unchanged; no rvalid; rdata keeps its previous value.
REQ-039 clear_req and req (load) in the same RUN cycle -> no rvalid, ready=0 next cycle; req during the sweep ignored; all words 0 afterwards.
REQ-040 rst pulsed low at sweep counter 7 -> outputs zero immediately; the sweep restarts at 0 and takes a full 2^ADDR_W cycles.
